// File: rtl/fprint_scratchpad_dp_if.sv
// Avalon-MM slave request/response bundle for one scratchpad port.
// The scratchpad consumes it through the slave modport; a driver uses master.
interface fprint_scratchpad_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [BE_WIDTH-1:0]   byteenable;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/fprint_scratchpad_dp.sv
// Dual-port Avalon-MM scratchpad: one array access per enabled cycle, shared
// between two round-robin arbitrated slave ports and a zero-fill clear engine.
// Reads return after exactly one cycle; the clear engine owns the array while
// clr_busy is high.
// Optional feature: define FPRINT_SCRATCHPAD_PARITY_EN to store one even
// parity bit per byte and report s1_parity_err / s2_parity_err on returns.
module fprint_scratchpad_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clken,
  input  logic                   reset_req,
  fprint_scratchpad_dp_if.slave  s1,
  fprint_scratchpad_dp_if.slave  s2,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   clr_done
`ifdef FPRINT_SCRATCHPAD_PARITY_EN
  ,
  output logic                   s1_parity_err,
  output logic                   s2_parity_err
`endif
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  logic                  en;
  logic                  req1, req2;
  logic                  gnt1, gnt2;
  logic                  rd1, rd2;
  logic                  last_s2_q, last_s2_d;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic                  clr_done_q, clr_done_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rdv1_q, rdv2_q;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata2_q;

  assign en   = clken & ~reset_req;
  assign req1 = s1.chipselect & (s1.read | s1.write);
  assign req2 = s2.chipselect & (s2.read | s2.write);

  // Round-robin arbiter: sole requester wins; a conflict goes to the port
  // that was not granted on the previous conflict.
  always_comb begin
    gnt1      = 1'b0;
    gnt2      = 1'b0;
    last_s2_d = last_s2_q;
    if (en && state_q == IDLE) begin
      if (req1 && req2) begin
        if (last_s2_q) gnt1 = 1'b1;
        else           gnt2 = 1'b1;
        last_s2_d = ~last_s2_q;
      end else begin
        gnt1 = req1;
        gnt2 = req2;
      end
    end
  end

  assign s1.waitrequest = req1 & ~gnt1;
  assign s2.waitrequest = req2 & ~gnt2;
  // read with write also asserted is a write
  assign rd1 = gnt1 & ~s1.write;
  assign rd2 = gnt2 & ~s2.write;

  // Clear FSM next-state: sweep every address once, then pulse clr_done.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req && en) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (en) begin
          clr_cnt_d = clr_cnt_q + CNT_ONE;
          // extra counter bit flags the pass over the last address
          if (clr_cnt_d[ADDR_WIDTH]) begin
            state_d    = IDLE;
            clr_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear FSM, done pulse and arbitration history registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
      last_s2_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_done_q <= clr_done_d;
      last_s2_q  <= last_s2_d;
    end
  end

  assign clr_busy = (state_q == CLEAR);
  assign clr_done = clr_done_q;

  // Single array access mux: clear engine, else the granted port.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = s1.address;
    mem_wdata = s1.writedata;
    mem_be    = s1.byteenable;
    if (state_q == CLEAR) begin
      mem_we    = en;
      mem_addr  = clr_cnt_q[ADDR_WIDTH-1:0];
      mem_wdata = '0;
      mem_be    = '1;
    end else if (gnt2) begin
      mem_we    = s2.write;
      mem_addr  = s2.address;
      mem_wdata = s2.writedata;
      mem_be    = s2.byteenable;
    end else if (gnt1) begin
      mem_we    = s1.write;
    end
  end

  // Byte-lane masked array write; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (mem_be[i]) mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
    end
  end

  // Read-return registers: capture on a granted read, freeze while en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv1_q   <= 1'b0;
      rdv2_q   <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else if (en) begin
      rdv1_q <= rd1;
      rdv2_q <= rd2;
      if (rd1) rdata1_q <= mem[mem_addr];
      if (rd2) rdata2_q <= mem[mem_addr];
    end
  end

  // A pending return is held back until the first enabled cycle.
  assign s1.readdatavalid = rdv1_q & en;
  assign s2.readdatavalid = rdv2_q & en;
  assign s1.readdata      = rdata1_q;
  assign s2.readdata      = rdata2_q;

`ifdef FPRINT_SCRATCHPAD_PARITY_EN
  logic [BE_WIDTH-1:0] par [DEPTH];
  logic                rd_perr;
  logic                perr1_q, perr2_q;

  // Parity write tracks the data write lane by lane (zero bytes give 0).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (mem_be[i]) par[mem_addr][i] <= ^mem_wdata[i*8 +: 8];
      end
    end
  end

  // Any byte whose stored parity disagrees with its data flags an error.
  always_comb begin
    rd_perr = 1'b0;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      if ((^mem[mem_addr][i*8 +: 8]) != par[mem_addr][i]) rd_perr = 1'b1;
    end
  end

  // Parity error flags travel alongside the read-return registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr1_q <= 1'b0;
      perr2_q <= 1'b0;
    end else if (en) begin
      perr1_q <= rd1 & rd_perr;
      perr2_q <= rd2 & rd_perr;
    end
  end

  assign s1_parity_err = perr1_q & en;
  assign s2_parity_err = perr2_q & en;
`endif

endmodule

// File: tb/tb_fprint_scratchpad_dp.sv
// Self-checking bench for fprint_scratchpad_dp (16-word, 32-bit instance).
// A word-level reference model predicts grants, returns and clear progress.
module tb_fprint_scratchpad_dp;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic reset_n, clken, reset_req, clr_req;
  logic clr_busy, clr_done;
`ifdef FPRINT_SCRATCHPAD_PARITY_EN
  logic s1_parity_err, s2_parity_err;
`endif

  fprint_scratchpad_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1_if ();
  fprint_scratchpad_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s2_if ();

  fprint_scratchpad_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .reset_req (reset_req),
    .s1        (s1_if),
    .s2        (s2_if),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
`ifdef FPRINT_SCRATCHPAD_PARITY_EN
    ,
    .s1_parity_err (s1_parity_err),
    .s2_parity_err (s2_parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] mem_m [NW];
  logic [3:0]  bad_m [NW];
  int          last_winner;
  bit          pend1, pend2, perr1, perr2;
  logic [31:0] hold1, hold2;
  bit          clearing, exp_done;
  int          caddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
    for (int l = 0; l < 4; l++) begin
      if (be[l]) begin
        mem_m[a][l*8 +: 8] = d[l*8 +: 8];
        bad_m[a][l] = 1'b0;
      end
    end
  endtask

  task automatic idle_ports();
    s1_if.chipselect = 0; s1_if.read = 0; s1_if.write = 0;
    s2_if.chipselect = 0; s2_if.read = 0; s2_if.write = 0;
    s1_if.address = '0; s1_if.byteenable = '0; s1_if.writedata = '0;
    s2_if.address = '0; s2_if.byteenable = '0; s2_if.writedata = '0;
  endtask

  task automatic drive1(input bit r, input bit w, input int a, input logic [31:0] d, input logic [3:0] be);
    s1_if.chipselect = r | w; s1_if.read = r; s1_if.write = w;
    s1_if.address = 4'(a); s1_if.writedata = d; s1_if.byteenable = be;
  endtask

  task automatic drive2(input bit r, input bit w, input int a, input logic [31:0] d, input logic [3:0] be);
    s2_if.chipselect = r | w; s2_if.read = r; s2_if.write = w;
    s2_if.address = 4'(a); s2_if.writedata = d; s2_if.byteenable = be;
  endtask

  // One clock: check the cycle's outputs against the model, then advance it.
  task automatic cycle();
    bit en, r1, r2, g1, g2, nxt_done;
    int a;
    @(negedge clk);
    en = clken && !reset_req;
    r1 = s1_if.chipselect && (s1_if.read || s1_if.write);
    r2 = s2_if.chipselect && (s2_if.read || s2_if.write);
    g1 = 0; g2 = 0;
    if (en && !clearing) begin
      if (r1 && r2) begin
        if (last_winner == 2) g1 = 1; else g2 = 1;
      end else begin
        g1 = r1; g2 = r2;
      end
    end
    chk("s1_waitrequest", 32'(s1_if.waitrequest), 32'(r1 && !g1));
    chk("s2_waitrequest", 32'(s2_if.waitrequest), 32'(r2 && !g2));
    chk("s1_readdatavalid", 32'(s1_if.readdatavalid), 32'(pend1 && en));
    chk("s2_readdatavalid", 32'(s2_if.readdatavalid), 32'(pend2 && en));
    chk("s1_readdata", s1_if.readdata, hold1);
    chk("s2_readdata", s2_if.readdata, hold2);
    chk("clr_busy", 32'(clr_busy), 32'(clearing));
    chk("clr_done", 32'(clr_done), 32'(exp_done));
`ifdef FPRINT_SCRATCHPAD_PARITY_EN
    chk("s1_parity_err", 32'(s1_parity_err), 32'(pend1 && en && perr1));
    chk("s2_parity_err", 32'(s2_parity_err), 32'(pend2 && en && perr2));
`endif
    if (r1 && r2 && (g1 || g2)) last_winner = g1 ? 1 : 2;
    if (en) begin pend1 = 0; pend2 = 0; end
    if (g1) begin
      a = int'(s1_if.address);
      if (s1_if.write) model_write(a, s1_if.writedata, s1_if.byteenable);
      else begin pend1 = 1; hold1 = mem_m[a]; perr1 = |bad_m[a]; end
    end
    if (g2) begin
      a = int'(s2_if.address);
      if (s2_if.write) model_write(a, s2_if.writedata, s2_if.byteenable);
      else begin pend2 = 1; hold2 = mem_m[a]; perr2 = |bad_m[a]; end
    end
    nxt_done = 0;
    if (clearing && en) begin
      mem_m[caddr] = '0;
      bad_m[caddr] = '0;
      caddr++;
      if (caddr == NW) begin clearing = 0; nxt_done = 1; end
    end else if (!clearing && en && clr_req) begin
      clearing = 1;
      caddr = 0;
    end
    exp_done = nxt_done;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_s1_rdv", 32'(s1_if.readdatavalid), 32'd0);
    chk("rst_s2_rdv", 32'(s2_if.readdatavalid), 32'd0);
    chk("rst_s1_rdata", s1_if.readdata, 32'd0);
    chk("rst_s2_rdata", s2_if.readdata, 32'd0);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    chk("rst_clr_done", 32'(clr_done), 32'd0);
    pend1 = 0; pend2 = 0; perr1 = 0; perr2 = 0;
    hold1 = '0; hold2 = '0;
    clearing = 0; caddr = 0; exp_done = 0;
    last_winner = 2;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin mem_m[i] = '0; bad_m[i] = '0; end
    reset_n = 1'b1; clken = 1'b1; reset_req = 1'b0; clr_req = 1'b0;
    idle_ports();
    #2;
    do_reset();

    // fill every word so later reads are defined
    for (int i = 0; i < NW; i++) begin
      drive1(0, 1, i, 32'hFFFF_FFFF, 4'hF);
      cycle();
    end

    // full write, lane-1 write, read back merged word
    drive1(0, 1, 10, 32'hA5A5_A5A5, 4'hF); cycle();
    drive1(0, 1, 10, 32'h0000_3C00, 4'h2); cycle();
    drive1(1, 0, 10, '0, 4'hF);            cycle();
    idle_ports();                          cycle();
    chk("merged_word", s1_if.readdata, 32'hA5A5_3CA5);

    // both ports reading every cycle: alternating grants, s1 first
    drive1(1, 0, 10, '0, 4'hF);
    drive2(1, 0, 3, '0, 4'hF);
    repeat (4) cycle();
    idle_ports();
    cycle();

    // s2 read granted, then 3 stalled cycles with both ports requesting
    drive2(1, 0, 10, '0, 4'hF); cycle();
    drive1(1, 0, 5, '0, 4'hF);
    clken = 1'b0;
    repeat (3) cycle();
    clken = 1'b1;
    idle_ports();
    cycle();
    chk("stall_return", s2_if.readdata, 32'hA5A5_3CA5);
    cycle();

    // full clear with s1 read in flight just before and requesting throughout
    drive1(1, 0, 10, '0, 4'hF);
    clr_req = 1'b1; cycle();
    clr_req = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (k == 3) clr_req = 1'b1;
      cycle();
      clr_req = 1'b0;
    end
    idle_ports();
    for (int i = 0; i < NW; i++) begin drive2(1, 0, i, '0, 4'hF); cycle(); end
    idle_ports(); cycle();
    chk("cleared_word15", s2_if.readdata, 32'd0);

    // refill, then reset with the clear counter at 5
    for (int i = 0; i < NW; i++) begin drive1(0, 1, i, 32'hFFFF_FFFF, 4'hF); cycle(); end
    idle_ports();
    clr_req = 1'b1; cycle();
    clr_req = 1'b0;
    for (int k = 0; k < 40 && !(clearing && caddr == 5); k++) cycle();
    do_reset();
    for (int i = 0; i < NW; i++) begin drive1(1, 0, i, '0, 4'hF); cycle(); end
    idle_ports(); cycle();
    chk("partial_clear_word15", s1_if.readdata, 32'hFFFF_FFFF);
    chk("partial_clear_word4", mem_m[4], 32'd0);

`ifdef FPRINT_SCRATCHPAD_PARITY_EN
    // corrupt one stored bit, read, rewrite, read again
    drive1(0, 1, 7, 32'h1234_5678, 4'hF); cycle();
    idle_ports(); cycle();
    dut.mem[7][9] = ~dut.mem[7][9];
    mem_m[7][9]   = ~mem_m[7][9];
    bad_m[7][1]   = 1'b1;
    drive1(1, 0, 7, '0, 4'hF); cycle();
    idle_ports(); cycle();
    drive1(0, 1, 7, 32'h1234_5678, 4'hF); cycle();
    drive1(1, 0, 7, '0, 4'hF); cycle();
    idle_ports(); cycle();
`endif

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      drive1($urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0, $urandom_range(NW - 1, 0),
             $urandom, 4'($urandom_range(15, 0)));
      drive2($urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0, $urandom_range(NW - 1, 0),
             $urandom, 4'($urandom_range(15, 0)));
      if ($urandom_range(3, 0) == 0) begin s1_if.chipselect = 0; end
      if ($urandom_range(3, 0) == 0) begin s2_if.chipselect = 0; end
      clken     = ($urandom_range(9, 0) != 0);
      reset_req = ($urandom_range(19, 0) == 0);
      clr_req   = ($urandom_range(59, 0) == 0);
      cycle();
    end
    idle_ports();
    clken = 1'b1; reset_req = 1'b0; clr_req = 1'b0;
    repeat (20) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
